// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: size encodings, LSU state enum, default memory size and request legality check shared by the load/store unit
package mips_mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;
  localparam int unsigned MEM_BYTES_DEF = 64;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;
  function automatic logic req_err(input logic [1:0] size, input logic [31:0] addr, input int unsigned mem_bytes);
    return size == SIZE_ILL
        || (size == SIZE_HALF && addr[0])
        || (size == SIZE_WORD && addr[1:0] != 2'b00)
        || addr > mem_bytes - 4
`ifndef LOAD_STORE_UNIT_SUBWORD_EN
        || size != SIZE_WORD
`endif
        ;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: MEM-stage request/response handshake plus data-memory bus; slave = LSU view, master = pipeline/memory view
interface load_store_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespError;
  logic [31:0] MemAddress;
  logic [31:0] MemDataOut;
  logic [31:0] MemDataIn;
  logic        MemRead;
  logic        MemWrite;
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemDataIn,
    output ReqReady, RespValid, RespRData, RespError, MemAddress, MemDataOut, MemRead, MemWrite
  );
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemDataIn,
    input  ReqReady, RespValid, RespRData, RespError, MemAddress, MemDataOut, MemRead, MemWrite
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extract with sign/zero extension (rdata) and sub-word store merge (merged); word/lane/size/sgn/wdata in, sub-word path only with LOAD_STORE_UNIT_SUBWORD_EN
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
`ifdef LOAD_STORE_UNIT_SUBWORD_EN
  logic [4:0]  sh;
  logic [15:0] lane_half;
  logic [31:0] keep;
  always_comb begin
    sh = {lane, 3'b000};
    lane_half = 16'(word >> sh);
    keep = size == SIZE_BYTE ? 32'h0000_00ff : size == SIZE_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    rdata = size == SIZE_BYTE ? {{24{sgn & lane_half[7]}}, lane_half[7:0]}
          : size == SIZE_HALF ? {{16{sgn & lane_half[15]}}, lane_half}
          : word;
    merged = (word & ~(keep << sh)) | ((wdata & keep) << sh);
  end
`else
  logic unused;
  assign unused = ^{lane, size, sgn};
  assign rdata  = word;
  assign merged = wdata;
`endif
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS data-memory initiator (Clk, Reset, bus = load_store_unit_if.slave); IDLE/RD/WR/RESP FSM with alignment checks, RMW sub-word stores under LOAD_STORE_UNIT_SUBWORD_EN
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input logic Clk,
  input logic Reset,
  load_store_unit_if.slave bus
);
  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata, merged;
  logic        err_in, err_q;
  logic        strobe;
  assign err_in = req_err(bus.ReqSize, bus.ReqAddr, MEM_BYTES);
  assign err_q  = req_err(size_q, addr_q, MEM_BYTES);
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    case (state_q)
      IDLE: if (bus.ReqValid) begin
        write_d  = bus.ReqWrite;
        size_d   = bus.ReqSize;
        signed_d = bus.ReqSigned;
        addr_d   = bus.ReqAddr;
        wdata_d  = bus.ReqWData;
        state_d  = err_in ? RESP : (bus.ReqWrite && bus.ReqSize == SIZE_WORD) ? WR : RD;
      end
      RD: begin
        buf_d   = bus.MemDataIn;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
    end
  end
  lsu_lane_align u_align (
    .word   (buf_q),
    .lane   (addr_q[1:0]),
    .size   (size_q),
    .sgn    (signed_q),
    .wdata  (wdata_q),
    .rdata  (rdata),
    .merged (merged)
  );
  assign strobe         = state_q == RD || state_q == WR;
  assign bus.ReqReady   = state_q == IDLE;
  assign bus.MemRead    = state_q == RD;
  assign bus.MemWrite   = state_q == WR;
  assign bus.RespValid  = state_q == RESP;
  assign bus.RespError  = state_q == RESP && err_q;
  assign bus.RespRData  = (state_q == RESP && !err_q && !write_q) ? rdata : '0;
  assign bus.MemAddress = strobe ? {addr_q[31:2], 2'b00} : '0;
  assign bus.MemDataOut = state_q == WR ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table-driven bench for load_store_unit with a 64-byte word memory model
module tb_load_store_unit;
  import mips_mem_pkg::*;
  logic Clk = 1'b0;
  logic Reset;
  logic load_mem;
  logic [31:0] mem [16];
  int total = 0;
  int bad = 0;
  always #5 Clk = ~Clk;
  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(64)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );
  assign bus.MemDataIn = mem[bus.MemAddress[5:2]];
  always @(posedge Clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4{i[7:0]}};
      mem[1] <= 32'h80FF7F01;
      mem[3] <= 32'h11223344;
    end else if (bus.MemWrite) mem[bus.MemAddress[5:2]] <= bus.MemDataOut;
  end
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mdo;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [31:0] rdata, input logic [31:0] mdo, input int lat);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.mdo = mdo; v.lat = lat;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v, input logic valid);
    bus.ReqValid  = valid;
    bus.ReqWrite  = v.wr;
    bus.ReqSize   = v.size;
    bus.ReqSigned = v.sgn;
    bus.ReqAddr   = v.addr;
    bus.ReqWData  = v.wdata;
  endtask
  task automatic run(input vec_t v, input int idx);
    int lat = 0;
    int nstr = 0;
    int nboth = 0;
    logic got = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge Clk);
    chk({tag, " ready"}, {31'd0, bus.ReqReady}, 32'd1);
    drive(v, 1'b1);
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge Clk);
      if (bus.MemRead && bus.MemWrite) nboth++;
      if (bus.MemRead || bus.MemWrite) begin
        nstr++;
        chk({tag, " maddr"}, bus.MemAddress, {v.addr[31:2], 2'b00});
      end
      if (bus.MemWrite) chk({tag, " mdo"}, bus.MemDataOut, v.mdo);
      if (bus.RespValid) begin
        got = 1'b1;
        lat = c;
        chk({tag, " err"}, {31'd0, bus.RespError}, {31'd0, v.err});
        chk({tag, " rdata"}, bus.RespRData, v.rdata);
      end
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " strobes"}, nstr, v.lat - 1);
    chk({tag, " both_strobes"}, nboth, 32'd0);
  endtask
  initial begin
    vec_t rv;
    int seen;
    int resp_at[$];
    drive(mk(0, SIZE_WORD, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    Reset = 1'b1;
    load_mem = 1'b1;
    repeat (2) @(posedge Clk);
    #1 load_mem = 1'b0;
    @(negedge Clk);
    chk("rst ReqReady", {31'd0, bus.ReqReady}, 32'd1);
    chk("rst RespValid", {31'd0, bus.RespValid}, 32'd0);
    chk("rst RespRData", bus.RespRData, 32'd0);
    chk("rst RespError", {31'd0, bus.RespError}, 32'd0);
    chk("rst MemRead", {31'd0, bus.MemRead}, 32'd0);
    chk("rst MemWrite", {31'd0, bus.MemWrite}, 32'd0);
    chk("rst MemAddress", bus.MemAddress, 32'd0);
    chk("rst MemDataOut", bus.MemDataOut, 32'd0);
    Reset = 1'b0;
    vecs.push_back(mk(1, SIZE_WORD, 0, 32'd8,  32'hDEADBEEF, 0, 32'h0,        32'hDEADBEEF, 2));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd8,  32'h0,        0, 32'hDEADBEEF, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_WORD, 1, 32'd4,  32'h0,        0, 32'h80FF7F01, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd2,  32'h0,        1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, SIZE_HALF, 0, 32'd5,  32'h1234,     1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd64, 32'h0,        1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_ILL,  0, 32'd0,  32'h0,        1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd60, 32'h0,        0, 32'h0F0F0F0F, 32'h0,        2));
    vecs.push_back(mk(1, SIZE_WORD, 0, 32'd60, 32'h12345678, 0, 32'h0,        32'h12345678, 2));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd60, 32'h0,        0, 32'h12345678, 32'h0,        2));
    vecs.push_back(mk(1, SIZE_WORD, 0, 32'd61, 32'h55555555, 1, 32'h0,        32'h0,        1));
`ifdef LOAD_STORE_UNIT_SUBWORD_EN
    vecs.push_back(mk(0, SIZE_BYTE, 1, 32'd7,  32'h0,        0, 32'hFFFFFF80, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_BYTE, 0, 32'd7,  32'h0,        0, 32'h00000080, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_HALF, 1, 32'd6,  32'h0,        0, 32'hFFFF80FF, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_HALF, 0, 32'd6,  32'h0,        0, 32'h000080FF, 32'h0,        2));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 32'd4,  32'h0,        0, 32'h00000001, 32'h0,        2));
    vecs.push_back(mk(1, SIZE_BYTE, 0, 32'd13, 32'hFFFFFFAA, 0, 32'h0,        32'h1122AA44, 3));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd12, 32'h0,        0, 32'h1122AA44, 32'h0,        2));
    vecs.push_back(mk(1, SIZE_HALF, 0, 32'd14, 32'h0000BEEF, 0, 32'h0,        32'hBEEFAA44, 3));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd12, 32'h0,        0, 32'hBEEFAA44, 32'h0,        2));
`else
    vecs.push_back(mk(1, SIZE_BYTE, 0, 32'd0,  32'h000000AA, 1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_HALF, 1, 32'd6,  32'h0,        1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_BYTE, 0, 32'd7,  32'h0,        1, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'd12, 32'h0,        0, 32'h11223344, 32'h0,        2));
`endif
    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);
    @(negedge Clk);
    rv = mk(1, SIZE_WORD, 0, 32'd0, 32'hCAFEF00D, 0, 0, 0, 0);
    drive(rv, 1'b1);
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    @(negedge Clk);
    chk("rstwr MemWrite", {31'd0, bus.MemWrite}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rstwr RespValid", {31'd0, bus.RespValid}, 32'd0);
    chk("rstwr ReqReady", {31'd0, bus.ReqReady}, 32'd1);
    chk("rstwr mem", mem[0], 32'hCAFEF00D);
    @(negedge Clk);
    chk("rstwr RespValid later", {31'd0, bus.RespValid}, 32'd0);
    run(mk(0, SIZE_WORD, 0, 32'd0, 32'h0, 0, 32'hCAFEF00D, 32'h0, 2), 100);
    @(negedge Clk);
    drive(mk(0, SIZE_WORD, 0, 32'd8, 0, 0, 0, 0, 0), 1'b1);
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    @(negedge Clk);
    chk("rstrd MemRead", {31'd0, bus.MemRead}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.RespValid) seen++;
      @(negedge Clk);
    end
    chk("rstrd no response", seen, 32'd0);
    drive(mk(0, SIZE_WORD, 0, 32'd8, 0, 0, 0, 0, 0), 1'b1);
    @(posedge Clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      if (bus.RespValid) resp_at.push_back(c);
    end
    bus.ReqValid = 1'b0;
    chk("b2b count", resp_at.size(), 32'd3);
    if (resp_at.size() == 3) begin
      chk("b2b first", resp_at[0], 32'd2);
      chk("b2b second", resp_at[1], 32'd5);
      chk("b2b third", resp_at[2], 32'd8);
    end
    repeat (4) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
